// File: rtl/gemm_pkg.sv
// Shared GEMM output-path definitions: datapath constants, writer states and
// the byte-enable mask helper used for partially filled SRAM words.
package gemm_pkg;

  localparam int GEMM_LANES      = 8;
  localparam int GEMM_DATA_WIDTH = 8;
  localparam int GEMM_SRAM_WIDTH = GEMM_LANES * GEMM_DATA_WIDTH;
  localparam int GEMM_WORD_BYTES = GEMM_SRAM_WIDTH / 8;
  localparam int GEMM_FILL_W     = $clog2(2 * GEMM_WORD_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Enables for the lowest 'fill' bytes of a word, i.e. (1 << fill) - 1.
  function automatic logic [GEMM_WORD_BYTES-1:0] be_mask(input logic [GEMM_FILL_W-1:0] fill);
    logic [GEMM_WORD_BYTES-1:0] mask;
    mask = '0;
    for (int i = 0; i < GEMM_WORD_BYTES; i++) begin
      mask[i] = (i < int'(fill));
    end
    return mask;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous first-word fall-through FIFO. A push into a full FIFO is
// accepted only when a pop happens in the same cycle; otherwise it is dropped.
module sync_fifo #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [PW:0]      count
);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_ok_s, pop_ok_s;

  assign empty = (count_q == '0);
  assign full  = (count_q == (PW+1)'(DEPTH));
  assign count = count_q;
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

  // Pointer, occupancy and storage updates for accepted pushes and pops.
  always_comb begin
    push_ok_s = push && (!full || pop);
    pop_ok_s  = pop && !empty;
    wr_ptr_d  = push_ok_s ? wr_ptr_q + PW'(1'b1) : wr_ptr_q;
    rd_ptr_d  = pop_ok_s ? rd_ptr_q + PW'(1'b1) : rd_ptr_q;
    mem_d     = mem_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = push_data;
    end else begin
      mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + (PW+1)'(1'b1);
      2'b01:   count_d = count_q - (PW+1)'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // Control state, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/requant_out_writer.sv
// Packs requantized int8 result vectors into SRAM words and streams them to the
// output SRAM from a programmed base address, tracking completion by byte count.
module requant_out_writer
  import gemm_pkg::*;
#(
  parameter int LANES      = GEMM_LANES,
  parameter int DATA_WIDTH = GEMM_DATA_WIDTH,
  parameter int SRAM_WIDTH = GEMM_SRAM_WIDTH,
  parameter int ADDR_WIDTH = 18,
  parameter int CNT_WIDTH  = 24,
  parameter int FIFO_DEPTH = 4,
  localparam int LW        = $clog2(LANES + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ADDR_WIDTH-1:0]       base_addr,
  input  logic [CNT_WIDTH-1:0]        total_bytes,
  input  logic                        in_valid,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  input  logic [LW-1:0]               in_num_lanes,
  output logic                        sram_wr_en,
  output logic [ADDR_WIDTH-1:0]       sram_wr_addr,
  output logic [SRAM_WIDTH-1:0]       sram_wr_data,
  output logic [SRAM_WIDTH/8-1:0]     sram_wr_be,
  input  logic                        sram_wr_ready,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow_o,
  output logic [CNT_WIDTH-1:0]        bytes_received
);

  localparam int BYTES  = SRAM_WIDTH / 8;
  localparam int ACC_W  = 2 * SRAM_WIDTH;
  localparam int FILL_W = $clog2(2 * BYTES);
  localparam int ENT_W  = BYTES + SRAM_WIDTH;
  localparam int FCW    = $clog2(FIFO_DEPTH) + 1;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   total_q, total_d;
  logic [CNT_WIDTH-1:0]   bytes_q, bytes_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic                   overflow_q, overflow_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [CNT_WIDTH-1:0]   remaining_s;
  logic [LW-1:0]          take_s;
  logic [SRAM_WIDTH-1:0]  lanes_s;
  logic [ACC_W-1:0]       merged_s;
  logic [FILL_W:0]        sum_s;
  logic                   push_s, pop_s, last_pop_s;
  logic [ENT_W-1:0]       push_word_s;
  logic [ENT_W-1:0]       head_s;
  logic                   fifo_full_s, fifo_empty_s;
  logic [FCW-1:0]         fifo_count_s;

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (push_word_s),
    .pop       (pop_s),
    .head      (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  assign pop_s          = !fifo_empty_s && sram_wr_ready;
  assign last_pop_s     = pop_s && (fifo_count_s == FCW'(1'b1));
  assign sram_wr_en     = !fifo_empty_s;
  assign sram_wr_addr   = addr_q;
  assign sram_wr_data   = head_s[SRAM_WIDTH-1:0];
  assign sram_wr_be     = head_s[ENT_W-1 -: BYTES];
  assign busy           = busy_q;
  assign done           = done_q;
  assign overflow_o     = overflow_q;
  assign bytes_received = bytes_q;

  // Clip the vector to the bytes still owed, then splice it in at the fill level.
  always_comb begin
    remaining_s = total_q - bytes_q;
    if (remaining_s < CNT_WIDTH'(in_num_lanes)) begin
      take_s = LW'(remaining_s);
    end else begin
      take_s = in_num_lanes;
    end
    lanes_s = '0;
    for (int i = 0; i < LANES; i++) begin
      lanes_s[i*DATA_WIDTH +: DATA_WIDTH] = (i < int'(take_s)) ? in_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
    merged_s = acc_q | ({{SRAM_WIDTH{1'b0}}, lanes_s} << {fill_q, 3'b000});
    sum_s    = {1'b0, fill_q} + (FILL_W+1)'(take_s);
  end

  // Sequencing of a layer, word pushes into the FIFO and address/overflow tracking.
  always_comb begin
    state_d     = state_q;
    total_d     = total_q;
    bytes_d     = bytes_q;
    addr_d      = addr_q;
    acc_d       = acc_q;
    fill_d      = fill_q;
    overflow_d  = overflow_q;
    push_s      = 1'b0;
    push_word_s = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          total_d    = total_bytes;
          bytes_d    = '0;
          addr_d     = base_addr;
          acc_d      = '0;
          fill_d     = '0;
          overflow_d = 1'b0;
          state_d    = (total_bytes == '0) ? ST_FLUSH : ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          bytes_d = bytes_q + CNT_WIDTH'(take_s);
          if (sum_s >= (FILL_W+1)'(BYTES)) begin
            push_s      = 1'b1;
            push_word_s = {{BYTES{1'b1}}, merged_s[SRAM_WIDTH-1:0]};
            acc_d       = merged_s >> SRAM_WIDTH;
            fill_d      = FILL_W'(sum_s - (FILL_W+1)'(BYTES));
          end else begin
            acc_d  = merged_s;
            fill_d = FILL_W'(sum_s);
          end
          state_d = (bytes_d == total_q) ? ST_FLUSH : ST_RUN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (fill_q != '0) begin
          push_s      = 1'b1;
          push_word_s = {BYTES'(be_mask(fill_q)), acc_q[SRAM_WIDTH-1:0]};
          acc_d       = '0;
          fill_d      = '0;
        end else if (fifo_empty_s || last_pop_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    addr_d     = pop_s ? addr_d + ADDR_WIDTH'(1'b1) : addr_d;
    overflow_d = overflow_d | (push_s && fifo_full_s && !pop_s);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
  end

  // State and output registers, cleared by the synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      total_q    <= '0;
      bytes_q    <= '0;
      addr_q     <= '0;
      acc_q      <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      bytes_q    <= bytes_d;
      addr_q     <= addr_d;
      acc_q      <= acc_d;
      fill_q     <= fill_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_requant_out_writer.sv
// Bench for requant_out_writer: directed scenarios plus randomized runs, all
// checked every cycle against a byte-queue / word-queue reference model.
module tb_requant_out_writer;

  localparam int AW = 18;
  localparam int CW = 24;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] total_bytes;
  logic          in_valid;
  logic [63:0]   in_data;
  logic [3:0]    in_num_lanes;
  logic          sram_wr_en;
  logic [AW-1:0] sram_wr_addr;
  logic [63:0]   sram_wr_data;
  logic [7:0]    sram_wr_be;
  logic          sram_wr_ready;
  logic          busy, done, overflow_o;
  logic [CW-1:0] bytes_received;

  requant_out_writer dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .total_bytes(total_bytes),
    .in_valid(in_valid), .in_data(in_data), .in_num_lanes(in_num_lanes),
    .sram_wr_en(sram_wr_en), .sram_wr_addr(sram_wr_addr), .sram_wr_data(sram_wr_data),
    .sram_wr_be(sram_wr_be), .sram_wr_ready(sram_wr_ready), .busy(busy), .done(done),
    .overflow_o(overflow_o), .bytes_received(bytes_received)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cyc = -1;

  // Reference model: phase 0 idle, 1 receiving, 2 draining, 3 completion pulse.
  int            m_phase = 0;
  int            m_total = 0;
  int            m_bytes = 0;
  logic [AW-1:0] m_addr  = '0;
  logic          m_ovf   = 1'b0;
  logic [7:0]    m_pend[$];
  logic [71:0]   m_fifo[$];

  // Writes observed on the SRAM port.
  logic [AW-1:0] wr_addr_q[$];
  logic [63:0]   wr_data_q[$];
  logic [7:0]    wr_be_q[$];
  int            wr_cyc_q[$];

  logic [63:0] vec_s[6];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_make_word(input int n);
    logic [63:0] d;
    logic [7:0]  be;
    d = '0;
    be = '0;
    for (int i = 0; i < n; i++) begin
      d[8*i +: 8] = m_pend.pop_front();
      be[i] = 1'b1;
    end
    if (m_fifo.size() >= FD) m_ovf = 1'b1;
    else m_fifo.push_back({be, d});
  endtask

  task automatic model_step();
    bit pop;
    int a;
    if (!rst) begin
      m_phase = 0; m_total = 0; m_bytes = 0; m_addr = '0; m_ovf = 1'b0;
      m_pend.delete(); m_fifo.delete();
      return;
    end
    pop = (m_fifo.size() > 0) && sram_wr_ready;
    if (pop) begin
      void'(m_fifo.pop_front());
      m_addr = m_addr + 1'b1;
    end
    case (m_phase)
      0: if (start) begin
        m_total = int'(total_bytes);
        m_bytes = 0;
        m_addr  = base_addr;
        m_ovf   = 1'b0;
        m_pend.delete();
        m_phase = (m_total == 0) ? 2 : 1;
      end
      1: if (in_valid) begin
        a = int'(in_num_lanes);
        if (a > m_total - m_bytes) a = m_total - m_bytes;
        for (int i = 0; i < a; i++) m_pend.push_back(in_data[8*i +: 8]);
        m_bytes += a;
        if (m_pend.size() >= 8) model_make_word(8);
        if (m_bytes == m_total) m_phase = 2;
      end
      2: begin
        if (m_pend.size() > 0) model_make_word(m_pend.size());
        else if (m_fifo.size() == 0) m_phase = 3;
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic compare_all();
    check_val("wr_en", sram_wr_en, m_fifo.size() > 0);
    if (m_fifo.size() > 0) begin
      check_val("wr_addr", sram_wr_addr, m_addr);
      check_val("wr_data", sram_wr_data, m_fifo[0][63:0]);
      check_val("wr_be", sram_wr_be, m_fifo[0][71:64]);
    end
    check_val("busy", busy, m_phase != 0);
    check_val("done", done, m_phase == 3);
    check_val("overflow", overflow_o, m_ovf);
    check_val("bytes_received", bytes_received, m_bytes);
    if (done) done_cyc = cyc;
  endtask

  task automatic tick();
    @(negedge clk);
    if (sram_wr_en && sram_wr_ready) begin
      wr_addr_q.push_back(sram_wr_addr);
      wr_data_q.push_back(sram_wr_data);
      wr_be_q.push_back(sram_wr_be);
      wr_cyc_q.push_back(cyc);
    end
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    compare_all();
  endtask

  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete(); wr_be_q.delete(); wr_cyc_q.delete();
    done_cyc = -1;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [CW-1:0] t);
    start = 1'b1; base_addr = b; total_bytes = t;
    tick();
    start = 1'b0;
  endtask

  task automatic send_vec(input logic [63:0] d, input int n);
    in_valid = 1'b1; in_data = d; in_num_lanes = 4'(n);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int max_cycles);
    int k;
    k = 0;
    while ((busy || m_phase != 0) && k < max_cycles) begin
      tick();
      k++;
    end
    check_val(tag, busy, 1'b0);
  endtask

  initial begin
    int s;
    int k;
    rst = 1'b0; start = 1'b0; base_addr = '0; total_bytes = '0;
    in_valid = 1'b0; in_data = '0; in_num_lanes = '0; sram_wr_ready = 1'b1;
    repeat (3) tick();
    check_val("rst_wr_en", sram_wr_en, 1'b0);
    check_val("rst_wr_addr", sram_wr_addr, 18'h0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_bytes", bytes_received, 24'h0);
    rst = 1'b1;
    tick();

    // Two full vectors make two full words.
    clear_logs();
    do_start(18'h100, 24'd16);
    send_vec(64'h0807060504030201, 8);
    send_vec(64'h100F0E0D0C0B0A09, 8);
    drain("t1_timeout", 20);
    check_val("t1_nwr", wr_addr_q.size(), 2);
    if (wr_addr_q.size() == 2) begin
      check_val("t1_addr0", wr_addr_q[0], 18'h100);
      check_val("t1_data0", wr_data_q[0], 64'h0807060504030201);
      check_val("t1_be0", wr_be_q[0], 8'hFF);
      check_val("t1_addr1", wr_addr_q[1], 18'h101);
      check_val("t1_data1", wr_data_q[1], 64'h100F0E0D0C0B0A09);
      check_val("t1_be1", wr_be_q[1], 8'hFF);
      check_val("t1_done_lat", done_cyc, wr_cyc_q[1] + 1);
    end

    // Partial vectors, flushed tail, address wrap at the top of SRAM.
    clear_logs();
    do_start(18'h3FFFF, 24'd9);
    send_vec(64'hFFFFFFFFFF030201, 3);
    send_vec(64'hFFFFFFFFFF060504, 3);
    send_vec(64'hFFFFFFFFFF090807, 3);
    drain("t2_timeout", 20);
    check_val("t2_nwr", wr_addr_q.size(), 2);
    if (wr_addr_q.size() == 2) begin
      check_val("t2_addr0", wr_addr_q[0], 18'h3FFFF);
      check_val("t2_data0", wr_data_q[0], 64'h0807060504030201);
      check_val("t2_be0", wr_be_q[0], 8'hFF);
      check_val("t2_addr1", wr_addr_q[1], 18'h00000);
      check_val("t2_data1", wr_data_q[1], 64'h0000000000000009);
      check_val("t2_be1", wr_be_q[1], 8'h01);
    end
    check_val("t2_bytes", bytes_received, 24'd9);

    // Lane clipping at the end of the layer.
    clear_logs();
    do_start(18'h20, 24'd5);
    send_vec(64'h0807060504030201, 8);
    drain("t3_timeout", 20);
    check_val("t3_nwr", wr_addr_q.size(), 1);
    if (wr_addr_q.size() == 1) begin
      check_val("t3_data", wr_data_q[0], 64'h0000000504030201);
      check_val("t3_be", wr_be_q[0], 8'h1F);
    end
    check_val("t3_bytes", bytes_received, 24'd5);
    check_val("t3_done_seen", done_cyc >= 0, 1'b1);

    // Backpressure: four words held, two dropped.
    clear_logs();
    sram_wr_ready = 1'b0;
    do_start(18'h200, 24'd48);
    for (int i = 0; i < 6; i++) begin
      vec_s[i] = {$urandom, $urandom};
      send_vec(vec_s[i], 8);
    end
    repeat (2) tick();
    check_val("t4_overflow", overflow_o, 1'b1);
    check_val("t4_held", sram_wr_en, 1'b1);
    sram_wr_ready = 1'b1;
    drain("t4_timeout", 20);
    check_val("t4_nwr", wr_addr_q.size(), 4);
    if (wr_addr_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check_val("t4_addr", wr_addr_q[i], 18'h200 + 18'(i));
        check_val("t4_data", wr_data_q[i], vec_s[i]);
      end
    end

    // Reset in the middle of a run with words queued.
    clear_logs();
    sram_wr_ready = 1'b0;
    do_start(18'h80, 24'd64);
    send_vec(64'h1111111111111111, 8);
    send_vec(64'h2222222222222222, 8);
    check_val("t5_queued", sram_wr_en, 1'b1);
    rst = 1'b0;
    tick();
    check_val("t5_wr_en", sram_wr_en, 1'b0);
    check_val("t5_busy", busy, 1'b0);
    check_val("t5_bytes", bytes_received, 24'h0);
    check_val("t5_addr", sram_wr_addr, 18'h0);
    check_val("t5_data", sram_wr_data, 64'h0);
    rst = 1'b1;
    sram_wr_ready = 1'b1;
    repeat (3) tick();
    check_val("t5_no_wr", wr_addr_q.size(), 0);
    do_start(18'h90, 24'd8);
    send_vec(64'hA5A5A5A5A5A5A5A5, 8);
    drain("t5_timeout", 20);
    check_val("t5_overflow", overflow_o, 1'b0);
    check_val("t5_nwr", wr_addr_q.size(), 1);

    // Zero-length layer, then a start while busy that must be ignored.
    clear_logs();
    s = cyc;
    do_start(18'h55, 24'd0);
    drain("t6_timeout", 10);
    check_val("t6_done_cyc", done_cyc, s + 2);
    check_val("t6_nwr", wr_addr_q.size(), 0);
    clear_logs();
    do_start(18'h40, 24'd16);
    do_start(18'h300, 24'd4);
    send_vec(64'h0123456789ABCDEF, 8);
    send_vec(64'hFEDCBA9876543210, 8);
    drain("t6b_timeout", 20);
    check_val("t6_bytes", bytes_received, 24'd16);
    check_val("t6b_nwr", wr_addr_q.size(), 2);
    if (wr_addr_q.size() == 2) begin
      check_val("t6_addr0", wr_addr_q[0], 18'h40);
      check_val("t6_addr1", wr_addr_q[1], 18'h41);
    end

    // Randomized layers with random lane counts, gaps, stalls and stray starts.
    for (int r = 0; r < 25; r++) begin
      do_start(AW'($urandom), CW'($urandom_range(0, 40)));
      k = 0;
      while (m_phase != 0 && k < 400) begin
        in_valid      = ($urandom_range(0, 9) < 7);
        in_num_lanes  = 4'($urandom_range(0, 8));
        in_data       = {$urandom, $urandom};
        sram_wr_ready = ($urandom_range(0, 9) < 8);
        start         = ($urandom_range(0, 19) == 0);
        base_addr     = AW'($urandom);
        total_bytes   = CW'($urandom_range(0, 40));
        tick();
        k++;
      end
      start = 1'b0; in_valid = 1'b0; sram_wr_ready = 1'b1;
      check_val("rand_finish", busy, 1'b0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
